// File: rtl/yc_chroma_timing.sv
// yc_chroma_timing: chroma subcarrier phase, colorburst window and PAL
// line-alternation generator for the Y/C encoder. Runs every video clock.
//
// Ports:
//   clk, reset_n      video clock, asynchronous active-low reset
//   hsync, vsync      sync inputs, active high
//   hblank            horizontal blank, active high
//   pal               0 = NTSC, 1 = PAL (shadowed at vsync rise)
//   phase_inc         subcarrier phase increment per clk (shadowed)
//   burst_range       {start[26:20], ntsc_end[19:10], pal_end[9:0]} (shadowed)
//   carrier_phase     subcarrier phase, top PHASE_W bits of the accumulator
//   burst_phase       carrier_phase plus standard-dependent burst offset
//   burst_en          inside the colorburst window
//   chroma_en         active video, chroma allowed
//   pal_alt           PAL V-switch state for the current line
//
// Pipeline: inputs are registered once for edge detection / line state,
// then every output is registered from that state, so all outputs share a
// 2-clk latency and stay mutually aligned.
module yc_chroma_timing #(
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned CNT_W   = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               hblank,
  input  logic               pal,
  input  logic [ACC_W-1:0]   phase_inc,
  input  logic [26:0]        burst_range,
  output logic [PHASE_W-1:0] carrier_phase,
  output logic [PHASE_W-1:0] burst_phase,
  output logic               burst_en,
  output logic               chroma_en,
  output logic               pal_alt
);

  localparam int unsigned RANGE_W = 27;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Burst offsets as fractions of a full turn: 1/2 (180), 5/8 (225), 3/8 (135).
  localparam logic [PHASE_W-1:0] OFF_NTSC  = PHASE_W'(2 ** (PHASE_W - 1));
  localparam logic [PHASE_W-1:0] OFF_PAL_A = PHASE_W'(5 * (2 ** (PHASE_W - 3)));
  localparam logic [PHASE_W-1:0] OFF_PAL_B = PHASE_W'(3 * (2 ** (PHASE_W - 3)));

  // Edge-detect / line-state registers
  logic               hsync_q;
  logic               vsync_q;
  logic               hblank_q;
  logic               loaded;
  logic [ACC_W-1:0]   shadow_inc;
  logic [RANGE_W-1:0] shadow_range;
  logic               shadow_pal;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               alt_q;

  // Combinational decode of the registered state
  logic               hs_fall;
  logic               vs_rise;
  logic               capture;
  logic [CNT_W-1:0]   burst_start;
  logic [CNT_W-1:0]   burst_end;
  logic               burst_nxt;
  logic [PHASE_W-1:0] carrier_nxt;
  logic [PHASE_W-1:0] burst_off;

  // Edge detection against the once-registered syncs
  always_comb begin
    hs_fall = hsync_q & ~hsync;
    vs_rise = vsync & ~vsync_q;
    // Shadows follow the inputs until the first vsync rise has latched them.
    capture = vs_rise | ~loaded;
  end

  // Output decode from the line state
  always_comb begin
    burst_start = CNT_W'(shadow_range[26:20]);
    burst_end   = shadow_pal ? CNT_W'(shadow_range[9:0]) : CNT_W'(shadow_range[19:10]);
    // An end at or before start yields an empty window by construction.
    burst_nxt   = ~hsync_q & (cnt >= burst_start) & (cnt < burst_end);
    carrier_nxt = acc[ACC_W-1 -: PHASE_W];
    burst_off   = OFF_NTSC;
    if (shadow_pal) begin
      burst_off = alt_q ? OFF_PAL_A : OFF_PAL_B;
    end
  end

  // Line state: syncs, shadows, accumulator, line counter, PAL switch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hblank_q     <= 1'b0;
      loaded       <= 1'b0;
      shadow_inc   <= '0;
      shadow_range <= '0;
      shadow_pal   <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      alt_q        <= 1'b0;
    end else begin
      hsync_q  <= hsync;
      vsync_q  <= vsync;
      hblank_q <= hblank;

      if (capture) begin
        shadow_inc   <= phase_inc;
        shadow_range <= burst_range;
        shadow_pal   <= pal;
      end
      if (vs_rise) begin
        loaded <= 1'b1;
      end

      acc <= acc + shadow_inc;

      // Saturating counter so an overlong line cannot re-open the burst window.
      if (hsync || hs_fall) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      // vsync clear takes priority over a coincident hsync toggle.
      if (vs_rise || !shadow_pal) begin
        alt_q <= 1'b0;
      end else if (hs_fall) begin
        alt_q <= ~alt_q;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carrier_phase <= '0;
      burst_phase   <= '0;
      burst_en      <= 1'b0;
      chroma_en     <= 1'b0;
      pal_alt       <= 1'b0;
    end else begin
      carrier_phase <= carrier_nxt;
      burst_phase   <= carrier_nxt + burst_off;
      burst_en      <= burst_nxt;
      chroma_en     <= ~hblank_q & ~vsync_q & ~burst_nxt;
      pal_alt       <= alt_q;
    end
  end

endmodule

// File: tb/tb_yc_chroma_timing.sv
// Scoreboard bench for yc_chroma_timing: a cycle reference model pushes the
// expected outputs each clock, a negedge monitor pops and compares.
module tb_yc_chroma_timing;

  localparam int unsigned ACC_W   = 40;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned CNT_W   = 10;

  logic               clk;
  logic               reset_n;
  logic               hsync;
  logic               vsync;
  logic               hblank;
  logic               pal;
  logic [ACC_W-1:0]   phase_inc;
  logic [26:0]        burst_range;
  logic [PHASE_W-1:0] carrier_phase;
  logic [PHASE_W-1:0] burst_phase;
  logic               burst_en;
  logic               chroma_en;
  logic               pal_alt;

  yc_chroma_timing #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .pal(pal), .phase_inc(phase_inc),
    .burst_range(burst_range), .carrier_phase(carrier_phase),
    .burst_phase(burst_phase), .burst_en(burst_en),
    .chroma_en(chroma_en), .pal_alt(pal_alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned carrier;
    int unsigned bphase;
    bit          burst;
    bit          chroma;
    bit          alt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // Reference model: phase as a 40-bit integer, line position as "clocks
  // since the hsync fall" capped at 1023, burst window from the line rules.
  localparam longint unsigned ACC_MASK = (64'd1 << ACC_W) - 64'd1;
  bit              m_hs_prev, m_vs_prev, m_hbl_prev, m_loaded, m_spal, m_alt;
  longint unsigned m_acc, m_sinc;
  int              m_start, m_ntsc_end, m_pal_end, m_cnt;

  always @(posedge clk) begin : model
    exp_t e;
    bit   rise, fall;
    int   wend, off;
    if (!reset_n) begin
      m_hs_prev = 0; m_vs_prev = 0; m_hbl_prev = 0; m_loaded = 0; m_spal = 0;
      m_alt = 0; m_acc = 0; m_sinc = 0; m_start = 0; m_ntsc_end = 0;
      m_pal_end = 0; m_cnt = 0;
      e = '{0, 0, 0, 0, 0};
    end else begin
      wend       = m_spal ? m_pal_end : m_ntsc_end;
      e.carrier  = 32'(m_acc >> (ACC_W - PHASE_W));
      e.burst    = !m_hs_prev && (m_cnt >= m_start) && (m_cnt < wend);
      e.chroma   = !m_hbl_prev && !m_vs_prev && !e.burst;
      e.alt      = m_alt;
      off        = !m_spal ? 128 : (m_alt ? 160 : 96);
      e.bphase   = (e.carrier + 32'(off)) % 256;

      rise = vsync && !m_vs_prev;
      fall = !hsync && m_hs_prev;
      if (hsync || fall) m_cnt = 0;
      else if (m_cnt < 1023) m_cnt = m_cnt + 1;
      if (rise || !m_spal) m_alt = 0;
      else if (fall) m_alt = !m_alt;
      m_acc = (m_acc + m_sinc) & ACC_MASK;
      if (rise || !m_loaded) begin
        m_sinc     = 64'(phase_inc);
        m_start    = int'(burst_range[26:20]);
        m_ntsc_end = int'(burst_range[19:10]);
        m_pal_end  = int'(burst_range[9:0]);
        m_spal     = pal;
      end
      if (rise) m_loaded = 1;
      m_hs_prev  = hsync;
      m_vs_prev  = vsync;
      m_hbl_prev = hblank;
    end
    sb_q.push_back(e);
  end

  // Monitor: outputs are valid every cycle; during reset they must read 0.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!reset_n) e = '{0, 0, 0, 0, 0};
      chk("carrier_phase", 32'(carrier_phase), e.carrier);
      chk("burst_phase",   32'(burst_phase),   e.bphase);
      chk("burst_en",      32'(burst_en),      32'(e.burst));
      chk("chroma_en",     32'(chroma_en),     32'(e.chroma));
      chk("pal_alt",       32'(pal_alt),       32'(e.alt));
    end
  end

  // Inputs change 3 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync_pulse(input int n);
    vsync = 1'b1;
    ticks(n);
    vsync = 1'b0;
  endtask

  // One line: hsync high hs_len clocks, then low act_len clocks with hblank
  // held for the first hbl_extra of them; returns the burst_en high count.
  task automatic run_line(input int hs_len, input int act_len, input int hbl_extra,
                          output int bursts);
    bursts = 0;
    hsync = 1'b1; hblank = 1'b1;
    for (int i = 0; i < hs_len; i++) begin
      tick();
      bursts += int'(burst_en);
    end
    hsync = 1'b0;
    for (int i = 0; i < act_len; i++) begin
      hblank = (i < hbl_extra);
      tick();
      bursts += int'(burst_en);
    end
  endtask

  localparam logic [26:0] RANGE_STD = {7'd35, 10'd116, 10'd0};

  initial begin
    int nb;
    reset_n = 1'b0; hsync = 1'b0; vsync = 1'b0; hblank = 1'b0; pal = 1'b0;
    phase_inc = '0; burst_range = '0;
    ticks(4);
    reset_n = 1'b1;

    // Accumulator stepping one phase LSB per clock, wrapping through 255.
    phase_inc = 40'd1 << 32; burst_range = RANGE_STD;
    vsync_pulse(2);
    ticks(300);
    phase_inc = 40'd45812728099;
    vsync_pulse(2);
    ticks(1000);

    // NTSC lines: 81-clock burst window each.
    for (int l = 0; l < 3; l++) begin
      run_line(64, 300, 10, nb);
      chk("ntsc_burst_len", 32'(nb), 32'd81);
    end

    // PAL with empty window; pal_alt toggles per line.
    pal = 1'b1;
    vsync_pulse(2);
    for (int l = 0; l < 3; l++) begin
      run_line(64, 200, 10, nb);
      chk("pal_burst_len", 32'(nb), 32'd0);
    end
    chk("pal_alt_odd", 32'(pal_alt), 32'd1);
    run_line(64, 200, 10, nb);
    chk("pal_alt_even", 32'(pal_alt), 32'd0);
    // Coincident hsync fall and vsync rise: clear must beat the toggle.
    hsync = 1'b1; ticks(10);
    hsync = 1'b0; vsync = 1'b1; ticks(3);
    vsync = 1'b0; ticks(3);
    chk("pal_alt_coincide", 32'(pal_alt), 32'd0);

    // Mid-frame changes are held off until the next vsync rise.
    pal = 1'b0; phase_inc = 40'd3 << 32;
    run_line(64, 200, 10, nb);
    chk("shadow_hold_burst", 32'(nb), 32'd0);
    vsync_pulse(2);
    run_line(64, 200, 10, nb);
    chk("shadow_apply_burst", 32'(nb), 32'd81);

    // Long line: counter saturates, burst does not repeat.
    run_line(10, 2000, 0, nb);
    chk("saturate_burst", 32'(nb), 32'd81);

    // Chroma gating.
    hblank = 1'b1; ticks(3);
    chk("chroma_hblank", 32'(chroma_en), 32'd0);
    hblank = 1'b0; vsync = 1'b1; ticks(3);
    chk("chroma_vsync", 32'(chroma_en), 32'd0);
    vsync = 1'b0; ticks(3);

    // Async reset mid-line.
    hsync = 1'b1; ticks(5); hsync = 1'b0; ticks(40);
    reset_n = 1'b0; #1;
    chk("async_rst_carrier", 32'(carrier_phase), 32'd0);
    chk("async_rst_burst_en", 32'(burst_en), 32'd0);
    ticks(2);
    reset_n = 1'b1;
    ticks(20);

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3, 0) == 0) begin
        phase_inc   = {8'($urandom), 32'($urandom)};
        pal         = 1'($urandom);
        burst_range = {7'($urandom_range(127, 0)), 10'($urandom_range(400, 0)),
                       10'($urandom_range(400, 0))};
      end
      if ($urandom_range(2, 0) == 0) vsync_pulse(int'($urandom_range(4, 1)));
      if ($urandom_range(7, 0) == 0) begin
        ticks(int'($urandom_range(30, 1)));
        reset_n = 1'b0;
        ticks(int'($urandom_range(3, 1)));
        reset_n = 1'b1;
      end
      hsync = 1'b1; vsync = 1'(($urandom_range(9, 0) == 0));
      ticks(int'($urandom_range(80, 1)));
      hsync = 1'b0;
      ticks(int'($urandom_range(3, 0)));
      vsync = 1'b0;
      run_line(int'($urandom_range(80, 1)), int'($urandom_range(600, 20)),
               int'($urandom_range(60, 0)), nb);
    end

    ticks(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
